nibble_serial_adder: RTL

Multi-cycle WIDTH-bit adder/subtractor that feeds operands one nibble per cycle through the team's 4-bit ripple adder slice and consumes its sum and carry-out, chaining the carry between passes. It sits directly in front of the 4-bit adder in the ALU datapath and widens it to 16-bit operations without replicating adder hardware. Operands enter and results leave on valid/ready handshakes.

---
 rtl/nibble_serial_adder_pkg.sv | 19 +
 rtl/nibble_serial_adder_if.sv | 27 ++
 rtl/nibble_serial_adder_adder4.sv | 23 ++
 rtl/nibble_serial_adder.sv | 129 ++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared ALU definitions for the nibble-serial adder: slice width, FSM states, result flags.
package nibble_serial_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned OPS_W    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flags_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle between the ALU front-end and the nibble-serial adder.
interface nibble_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/nibble_serial_adder_adder4.sv
// nibble_adder4: combinational 4-bit ripple-carry adder slice.
module nibble_adder4
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a4,
    input  logic [NIBBLE_W-1:0] b4,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s4,
    output logic                co
);
    logic [NIBBLE_W:0] c;

    always_comb begin
        c    = '0;
        s4   = '0;
        c[0] = ci;
        for (int i = 0; i < int'(NIBBLE_W); i++) begin
            s4[i]  = a4[i] ^ b4[i] ^ c[i];
            c[i+1] = (a4[i] & b4[i]) | (c[i] & (a4[i] ^ b4[i]));
        end
        co = c[NIBBLE_W];
    end
endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract done one nibble per cycle through a single nibble_adder4.
// Optional ops_done completed-operation counter enabled by NSA_PERF_CNT_EN.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    nibble_serial_adder_if.slave      bus
`ifdef NSA_PERF_CNT_EN
    ,
    output logic [OPS_W-1:0]          ops_done
`endif
);
    localparam int unsigned NIBBLES  = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e           state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    flags_t           flags_q;

    logic [NIBBLE_W-1:0] a4_c;
    logic [NIBBLE_W-1:0] b4_c;
    logic [NIBBLE_W-1:0] s4_c;
    logic                co_c;
    logic [WIDTH-1:0]    sum_next_c;
    flags_t              flags_next_c;

    // Nibble multiplexer feeding the shared slice
    assign a4_c = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
    assign b4_c = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

    nibble_adder4 u_adder4 (
        .a4 (a4_c),
        .b4 (b4_c),
        .ci (carry_q),
        .s4 (s4_c),
        .co (co_c)
    );

    // Full sum including the nibble produced this cycle; flags are only meaningful on the last pass
    always_comb begin
        sum_next_c = sum_q;
        sum_next_c[NIBBLE_W*idx_q +: NIBBLE_W] = s4_c;
        flags_next_c.cout = co_c;
        flags_next_c.ovf  = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_next_c[WIDTH-1] ^ co_c;
        flags_next_c.zero = (sum_next_c == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            flags_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.sub ? ~bus.b : bus.b;
                        carry_q    <= bus.sub | bus.cin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_next_c;
                    carry_q <= co_c;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        flags_q     <= flags_next_c;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = flags_q.cout;
    assign bus.ovf       = flags_q.ovf;
    assign bus.zero      = flags_q.zero;

`ifdef NSA_PERF_CNT_EN
    logic [OPS_W-1:0] ops_q;

    // Saturating count of result handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_q <= '0;
        end else if (out_valid_q && bus.out_ready && (ops_q != {OPS_W{1'b1}})) begin
            ops_q <= ops_q + OPS_W'(1);
        end
    end

    assign ops_done = ops_q;
`endif

endmodule
